// File: rtl/sata_cmd_sched.sv
// SATA command scheduler: round-robin arbitration of host command channels onto
// one FIS stream, then a wait for device status (or a timeout) and a per-channel completion pulse.
module sata_cmd_sched #(
    parameter int N_CH       = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_DWORDS = 5,
    parameter int TIMEOUT_W  = 24,
    localparam int GW        = $clog2(N_CH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       linkup,
    input  logic [TIMEOUT_W-1:0]       timeout_cycles,
    input  logic [N_CH-1:0]            cmd_valid,
    output logic [N_CH-1:0]            cmd_ready,
    input  logic [N_CH*DATA_WIDTH-1:0] cmd_data,
    input  logic [N_CH-1:0]            cmd_last,
    output logic                       fis_valid,
    input  logic                       fis_ready,
    output logic [DATA_WIDTH-1:0]      fis_data,
    output logic                       fis_last,
    output logic [GW-1:0]              fis_ch,
    input  logic                       sts_valid,
    input  logic                       sts_err,
    output logic [N_CH-1:0]            done,
    output logic [N_CH-1:0]            done_err,
    output logic                       busy
);

    localparam int CW = $clog2(MAX_DWORDS + 1);

    typedef enum logic [1:0] {IDLE, XFER, WAIT_STS, CPL} state_t;

    state_t                state_q;
    logic [GW-1:0]         grant_q;
    logic [GW-1:0]         last_grant_q;
    logic [GW-1:0]         pick;
    logic [CW-1:0]         cnt_q;
    logic [TIMEOUT_W-1:0]  tmo_q;
    logic                  err_q;
    logic                  busy_q;
    logic [N_CH-1:0]       done_q;
    logic [N_CH-1:0]       done_err_q;
    logic [N_CH-1:0]       grant_oh;
    logic                  xfer_act;
    logic                  fire;
    logic                  cap_hit;
    logic                  tmo_hit;
    logic                  found;
    int unsigned           idx;

    // Round-robin search starting one past the previous grant, wrapping at N_CH.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned i = 1; i <= 32'(N_CH); i++) begin
            idx = (32'(last_grant_q) + i) % 32'(N_CH);
            if (!found && cmd_valid[idx[GW-1:0]]) begin
                pick  = idx[GW-1:0];
                found = 1'b1;
            end
        end
    end

    // Link loss stalls the stream so no dword is handed over that the command will never own.
    assign xfer_act  = (state_q == XFER) && linkup;
    assign grant_oh  = N_CH'(1) << grant_q;
    assign fis_valid = xfer_act && cmd_valid[grant_q];
    assign fis_data  = cmd_data[32'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
    assign cap_hit   = (cnt_q == CW'(MAX_DWORDS - 1));
    assign fis_last  = cmd_last[grant_q] | cap_hit;
    assign cmd_ready = xfer_act ? (grant_oh & {N_CH{fis_ready}}) : '0;
    assign fire      = fis_valid && fis_ready;
    assign tmo_hit   = (timeout_cycles != '0) && (tmo_q == timeout_cycles - TIMEOUT_W'(1));
    assign fis_ch    = grant_q;
    assign done      = done_q;
    assign done_err  = done_err_q;
    assign busy      = busy_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(N_CH - 1);
            cnt_q        <= '0;
            tmo_q        <= '0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= '0;
            done_err_q   <= '0;
        end else begin
            done_q     <= '0;
            done_err_q <= '0;
            unique case (state_q)
                IDLE: begin
                    if (linkup && (|cmd_valid)) begin
                        grant_q <= pick;
                        cnt_q   <= '0;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= XFER;
                    end
                end
                XFER: begin
                    if (!linkup) begin
                        err_q      <= 1'b1;
                        done_q     <= grant_oh;
                        done_err_q <= grant_oh;
                        state_q    <= CPL;
                    end else if (fire) begin
                        cnt_q <= cnt_q + CW'(1);
                        if (cap_hit && !cmd_last[grant_q]) begin
                            err_q <= 1'b1;
                        end
                        if (fis_last) begin
                            tmo_q   <= '0;
                            state_q <= WAIT_STS;
                        end
                    end
                end
                WAIT_STS: begin
                    tmo_q <= tmo_q + TIMEOUT_W'(1);
                    if (!linkup || (!sts_valid && tmo_hit)) begin
                        err_q      <= 1'b1;
                        done_q     <= grant_oh;
                        done_err_q <= grant_oh;
                        state_q    <= CPL;
                    end else if (sts_valid) begin
                        err_q      <= err_q | sts_err;
                        done_q     <= grant_oh;
                        done_err_q <= (err_q | sts_err) ? grant_oh : '0;
                        state_q    <= CPL;
                    end
                end
                CPL: begin
                    last_grant_q <= grant_q;
                    busy_q       <= 1'b0;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sata_cmd_sched.sv
// Self-checking bench for sata_cmd_sched: directed scenarios plus randomized rounds,
// checked cycle by cycle against a queue-based model of channel sources and command lifecycle.
module tb_sata_cmd_sched;

    localparam int N_CH = 4;
    localparam int DW   = 32;
    localparam int MAXD = 5;
    localparam int TW   = 24;
    localparam int GW   = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              linkup;
    logic [TW-1:0]     timeout_cycles;
    logic [N_CH-1:0]   cmd_valid;
    logic [N_CH-1:0]   cmd_ready;
    logic [N_CH*DW-1:0] cmd_data;
    logic [N_CH-1:0]   cmd_last;
    logic              fis_valid;
    logic              fis_ready;
    logic [DW-1:0]     fis_data;
    logic              fis_last;
    logic [GW-1:0]     fis_ch;
    logic              sts_valid;
    logic              sts_err;
    logic [N_CH-1:0]   done;
    logic [N_CH-1:0]   done_err;
    logic              busy;

    always #5 clk = ~clk;

    sata_cmd_sched #(
        .N_CH(N_CH), .DATA_WIDTH(DW), .MAX_DWORDS(MAXD), .TIMEOUT_W(TW)
    ) dut (
        .clk(clk), .rst(rst), .linkup(linkup), .timeout_cycles(timeout_cycles),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data), .cmd_last(cmd_last),
        .fis_valid(fis_valid), .fis_ready(fis_ready), .fis_data(fis_data), .fis_last(fis_last),
        .fis_ch(fis_ch), .sts_valid(sts_valid), .sts_err(sts_err),
        .done(done), .done_err(done_err), .busy(busy)
    );

    typedef enum {M_IDLE, M_XFER, M_WAIT, M_CPL} ph_t;

    int tests = 0;
    int fails = 0;

    // Channel sources: flat dword streams, bit DW is the cmd_last flag.
    logic [DW:0] mem [N_CH][128];
    int hd [N_CH];
    int tl [N_CH];

    ph_t mph;
    int  g, lastg, cnt, waited;
    bit  merr;

    int  ready_mode, sts_delay, tmo_val, drop_k, link_down;
    bit  sts_err_v, noise;
    int  cyc, n_done, n_derr, done_cyc, lf_cyc;
    int  order_q[$];
    int  nd0, ne0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_cmd(input int ch, input int len);
        if (hd[ch] == tl[ch]) begin
            hd[ch] = 0;
            tl[ch] = 0;
        end
        for (int k = 0; k < len; k++) begin
            mem[ch][tl[ch]] = {(k == len - 1), 32'($urandom)};
            tl[ch]++;
        end
    endtask

    task automatic cycle();
        logic [N_CH-1:0] ohg;
        bit fv_e, last_e, src_last, any_v, fnd;
        @(negedge clk);
        rst = 1'b0;
        if (mph == M_WAIT && waited == drop_k) begin
            link_down = 3;
            drop_k    = -1;
        end
        linkup = (link_down == 0);
        for (int i = 0; i < N_CH; i++) begin
            cmd_valid[i]          = (hd[i] < tl[i]);
            cmd_data[i*DW +: DW]  = (hd[i] < tl[i]) ? mem[i][hd[i]][DW-1:0] : '0;
            cmd_last[i]           = (hd[i] < tl[i]) ? mem[i][hd[i]][DW] : 1'b0;
        end
        case (ready_mode)
            0:       fis_ready = 1'b1;
            1:       fis_ready = (cyc % 2 == 0);
            default: fis_ready = 1'($urandom_range(0, 1));
        endcase
        if (mph == M_WAIT) begin
            sts_valid = (waited == sts_delay);
            sts_err   = sts_err_v;
        end else begin
            sts_valid = noise && ($urandom_range(0, 1) == 1);
            sts_err   = 1'($urandom_range(0, 1));
        end
        timeout_cycles = TW'(tmo_val);
        #1;
        ohg  = N_CH'(1) << g;
        fv_e = (mph == M_XFER) && linkup && (hd[g] < tl[g]);
        chk("busy", busy, mph != M_IDLE);
        chk("fis_valid", fis_valid, fv_e);
        chk("cmd_ready", cmd_ready, (mph == M_XFER && linkup && fis_ready) ? ohg : '0);
        chk("done", done, (mph == M_CPL) ? ohg : '0);
        chk("done_err", done_err, (mph == M_CPL && merr) ? ohg : '0);
        src_last = 1'b0;
        last_e   = 1'b0;
        if (fv_e) begin
            src_last = mem[g][hd[g]][DW];
            last_e   = src_last || (cnt == MAXD - 1);
            chk("fis_ch", fis_ch, g);
            chk("fis_data", fis_data, mem[g][hd[g]][DW-1:0]);
            chk("fis_last", fis_last, last_e);
        end
        if (done != '0) begin
            n_done++;
            done_cyc = cyc;
        end
        if (done_err != '0) n_derr++;
        case (mph)
            M_IDLE: begin
                any_v = 1'b0;
                fnd   = 1'b0;
                for (int k = 1; k <= N_CH; k++) begin
                    int c;
                    c = (lastg + k) % N_CH;
                    if (!fnd && hd[c] < tl[c]) begin
                        fnd = 1'b1;
                        if (linkup) g = c;
                    end
                end
                any_v = fnd;
                if (linkup && any_v) begin
                    cnt  = 0;
                    merr = 1'b0;
                    mph  = M_XFER;
                end
            end
            M_XFER: begin
                if (!linkup) begin
                    merr = 1'b1;
                    mph  = M_CPL;
                end else if (fv_e && fis_ready) begin
                    if (cnt == 0) order_q.push_back(int'(fis_ch));
                    if (cnt == MAXD - 1 && !src_last) merr = 1'b1;
                    hd[g]++;
                    cnt++;
                    if (last_e) begin
                        mph    = M_WAIT;
                        waited = 0;
                        lf_cyc = cyc;
                    end
                end
            end
            M_WAIT: begin
                if (!linkup) begin
                    merr = 1'b1;
                    mph  = M_CPL;
                end else if (sts_valid) begin
                    merr = merr | sts_err;
                    mph  = M_CPL;
                end else if (tmo_val != 0 && waited == tmo_val - 1) begin
                    merr = 1'b1;
                    mph  = M_CPL;
                end
                waited++;
            end
            default: begin
                lastg = g;
                mph   = M_IDLE;
            end
        endcase
        if (link_down > 0) link_down--;
        cyc++;
    endtask

    task automatic run(input int budget);
        int  n;
        bit  empty;
        n = 0;
        do begin
            cycle();
            n++;
            empty = 1'b1;
            for (int i = 0; i < N_CH; i++) if (hd[i] < tl[i]) empty = 1'b0;
        end while (!(mph == M_IDLE && empty && link_down == 0) && n < budget);
        chk("drain_budget", (n < budget), 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        cmd_valid = '0;
        cmd_last  = '0;
        sts_valid = 1'b0;
        fis_ready = 1'b0;
        linkup    = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, '0);
        chk("rst_done_err", done_err, '0);
        chk("rst_fis_valid", fis_valid, 1'b0);
        chk("rst_cmd_ready", cmd_ready, '0);
        chk("rst_fis_ch", fis_ch, '0);
        mph       = M_IDLE;
        g         = 0;
        lastg     = N_CH - 1;
        cnt       = 0;
        waited    = 0;
        merr      = 1'b0;
        link_down = 0;
        for (int i = 0; i < N_CH; i++) begin
            hd[i] = 0;
            tl[i] = 0;
        end
    endtask

    task automatic setup(input int rm, input int sd, input bit se, input bit nz, input int tv, input int dk);
        ready_mode = rm;
        sts_delay  = sd;
        sts_err_v  = se;
        noise      = nz;
        tmo_val    = tv;
        drop_k     = dk;
        order_q.delete();
        nd0 = n_done;
        ne0 = n_derr;
    endtask

    initial begin
        rst = 1'b1; linkup = 1'b1; timeout_cycles = '0; cmd_valid = '0; cmd_data = '0;
        cmd_last = '0; fis_ready = 1'b0; sts_valid = 1'b0; sts_err = 1'b0;
        cyc = 0; n_done = 0; n_derr = 0; done_cyc = 0; lf_cyc = 0;
        setup(0, -1, 1'b0, 1'b0, 0, -1);
        do_reset();

        // Two simultaneous 5-dword commands: channel 0 first, then 2.
        setup(0, 10, 1'b0, 1'b0, 1000, -1);
        push_cmd(0, 5);
        push_cmd(2, 5);
        run(2000);
        chk("rr_cmds", order_q.size(), 2);
        chk("rr_first", (order_q.size() > 0) ? order_q[0] : -1, 0);
        chk("rr_second", (order_q.size() > 1) ? order_q[1] : -1, 2);
        chk("rr_dones", n_done - nd0, 2);
        chk("rr_errs", n_derr - ne0, 0);

        // Six dwords offered: capped at five and errored; the sixth forms its own command.
        setup(0, 3, 1'b0, 1'b0, 1000, -1);
        push_cmd(1, 6);
        run(2000);
        chk("cap_dones", n_done - nd0, 2);
        chk("cap_errs", n_derr - ne0, 1);

        // Timeout of 100 with no status.
        setup(0, -1, 1'b0, 1'b0, 100, -1);
        push_cmd(3, 2);
        run(2000);
        chk("tmo_latency", done_cyc - lf_cyc, 101);
        chk("tmo_err", n_derr - ne0, 1);

        // Timeout disabled, late error status.
        setup(0, 5000, 1'b1, 1'b0, 0, -1);
        push_cmd(0, 1);
        run(8000);
        chk("notmo_latency", done_cyc - lf_cyc, 5002);
        chk("notmo_err", n_derr - ne0, 1);

        // Alternating fis_ready with stray status strobes outside WAIT_STS.
        setup(1, 2, 1'b0, 1'b1, 50, -1);
        push_cmd(1, 5);
        push_cmd(3, 5);
        run(2000);
        chk("toggle_dones", n_done - nd0, 2);
        chk("toggle_order", (order_q.size() > 0) ? order_q[0] : -1, 1);

        // Status in the same cycle the timeout expires wins.
        setup(0, 7, 1'b0, 1'b0, 8, -1);
        push_cmd(2, 3);
        run(2000);
        chk("prio_latency", done_cyc - lf_cyc, 9);
        chk("prio_err", n_derr - ne0, 0);

        // Link drop during WAIT_STS, stray status afterwards.
        setup(0, -1, 1'b0, 1'b1, 0, 2);
        push_cmd(0, 2);
        run(2000);
        chk("drop_latency", done_cyc - lf_cyc, 4);
        chk("drop_err", n_derr - ne0, 1);

        // Reset mid-transfer abandons the command silently and restarts arbitration at 0.
        setup(0, -1, 1'b0, 1'b0, 0, -1);
        push_cmd(2, 5);
        for (int k = 0; k < 3; k++) cycle();
        do_reset();
        chk("rst_no_done", n_done - nd0, 0);
        setup(0, 1, 1'b0, 1'b0, 0, -1);
        push_cmd(1, 1);
        push_cmd(0, 1);
        run(500);
        chk("rst_rr_first", (order_q.size() > 0) ? order_q[0] : -1, 0);

        // Randomized rounds.
        for (int r = 0; r < 15; r++) begin
            int mask;
            setup($urandom_range(0, 2), $urandom_range(0, 40), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(4, 30),
                  ($urandom_range(0, 5) == 0) ? $urandom_range(0, 3) : -1);
            mask = $urandom_range(1, 15);
            for (int c = 0; c < N_CH; c++)
                if (mask[c]) push_cmd(c, $urandom_range(1, 7));
            run(5000);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
